// File: rtl/async_event_arbiter.sv
// Synchronizes, debounces and arbitrates WIDTH asynchronous level inputs,
// reporting each accepted level change as a single valid/ready event.
module async_event_arbiter #(
  parameter int WIDTH    = 4,
  parameter int LENGTH   = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(WIDTH)-1:0] evt_index,
  output logic                     evt_level,
  output logic [WIDTH-1:0]         overflow,
  input  logic                     ovf_clear
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  sync_q [LENGTH];
  logic [WIDTH-1:0]  sync;
  logic [CW-1:0]     cnt [WIDTH];
  logic [WIDTH-1:0]  mismatch;
  logic [WIDTH-1:0]  toggle;
  logic [WIDTH-1:0]  pending;
  logic [WIDTH-1:0]  acc_clear;
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [IW-1:0]     idx_nxt;
  logic              lvl_nxt;
  logic              valid_nxt;
  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic              accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LENGTH; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int k = 1; k < LENGTH; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync = sync_q[LENGTH-1];

  // A toggle needs DEBOUNCE back-to-back mismatching samples; any match restarts the count.
  always_comb begin
    mismatch = '0;
    toggle   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mismatch[i] = sync[i] ^ level[i];
      toggle[i]   = mismatch[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      level <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!mismatch[i] || toggle[i]) cnt[i] <= '0;
        else                           cnt[i] <= cnt[i] + CW'(1);
      end
      level <= level ^ toggle;
    end
  end

  assign accept    = evt_valid && evt_ready;
  assign acc_clear = accept ? (WIDTH'(1) << evt_index) : '0;

  // A new toggle re-arms pending even on the edge its previous event is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= toggle | (pending & ~acc_clear);
      overflow <= (toggle & pending & ~acc_clear) | (ovf_clear ? '0 : overflow);
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!pick_found && pending[(int'(ptr) + k) % WIDTH]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(ptr) + k) % WIDTH);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = evt_index;
    lvl_nxt   = evt_level;
    valid_nxt = evt_valid;
    case (state)
      IDLE: begin
        if (pick_found) begin
          idx_nxt   = pick_idx;
          lvl_nxt   = level[pick_idx];
          valid_nxt = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          valid_nxt = 1'b0;
          ptr_nxt   = IW'((int'(evt_index) + 1) % WIDTH);
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      evt_valid <= 1'b0;
      evt_index <= '0;
      evt_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      evt_valid <= valid_nxt;
      evt_index <= idx_nxt;
      evt_level <= lvl_nxt;
    end
  end

  a_offer_stable: assert property (@(posedge clk) disable iff (rst)
    evt_valid && !evt_ready |=> evt_valid && $stable(evt_index) && $stable(evt_level));

  a_offer_pending: assert property (@(posedge clk) disable iff (rst)
    evt_valid |-> pending[evt_index]);

  a_ptr_range: assert property (@(posedge clk) disable iff (rst)
    int'(ptr) < WIDTH);

endmodule

// File: tb/tb_async_event_arbiter.sv
// Bench for async_event_arbiter: directed scenarios plus random traffic,
// all compared against a window-based behavioural model.
module tb_async_event_arbiter;

  localparam int W  = 4;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  d = '0;
  logic          evt_ready = 1'b0;
  logic          ovf_clear = 1'b0;
  logic [W-1:0]  level;
  logic [W-1:0]  overflow;
  logic          evt_valid;
  logic [IW-1:0] evt_index;
  logic          evt_level;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0]  m_level, m_pend, m_ovf;
  logic          m_valid, m_lvl;
  int            m_idx, m_ptr;
  int            since [W];
  logic [W-1:0]  dq [$];
  int            acc_log [$];

  always #5 clk = ~clk;

  async_event_arbiter #(.WIDTH(W), .LENGTH(L), .DEBOUNCE(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .level     (level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_index (evt_index),
    .evt_level (evt_level),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0; m_pend = '0; m_ovf = '0;
    m_valid = 1'b0; m_lvl = 1'b0; m_idx = 0; m_ptr = 0;
    for (int i = 0; i < W; i++) since[i] = 0;
    dq.delete();
    repeat (L + D) dq.push_back('0);
  endtask

  // A channel flips once the last D synchronized samples, all taken since its previous flip, disagree with it.
  task automatic model_edge();
    logic [W-1:0] tog, clr;
    bit all_diff;
    dq.push_front(d);
    while (dq.size() > L + D) void'(dq.pop_back());
    tog = '0;
    for (int i = 0; i < W; i++) begin
      if (since[i] < D) since[i]++;
      if (since[i] >= D) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (dq[L+j][i] == m_level[i]) all_diff = 1'b0;
        if (all_diff) begin
          tog[i] = 1'b1;
          since[i] = 0;
        end
      end
    end
    clr = (m_valid && evt_ready) ? W'(1 << m_idx) : '0;
    m_ovf = (tog & m_pend & ~clr) | (ovf_clear ? '0 : m_ovf);
    if (m_valid) begin
      if (evt_ready) begin
        m_valid = 1'b0;
        m_ptr = (m_idx + 1) % W;
      end
    end else if (m_pend != '0) begin
      for (int k = W - 1; k >= 0; k--) begin
        if (m_pend[(m_ptr + k) % W]) m_idx = (m_ptr + k) % W;
      end
      m_lvl = m_level[m_idx];
      m_valid = 1'b1;
    end
    m_pend = tog | (m_pend & ~clr);
    m_level = m_level ^ tog;
  endtask

  task automatic step();
    if (evt_valid === 1'b1 && evt_ready) acc_log.push_back(int'(evt_index));
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    checkOutput("level", level, m_level);
    checkOutput("evt_valid", evt_valid, m_valid);
    checkOutput("overflow", overflow, m_ovf);
    if (m_valid) begin
      checkOutput("evt_index", evt_index, m_idx);
      checkOutput("evt_level", evt_level, m_lvl);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] dv, input logic rdy, input logic clr, input int n);
    d = dv; evt_ready = rdy; ovf_clear = clr;
    repeat (n) step();
  endtask

  task automatic wait_offer(input int maxc);
    int c = 0;
    while (evt_valid !== 1'b1 && c < maxc) begin
      step();
      c++;
    end
    checkOutput("offer_timeout", evt_valid, 1);
  endtask

  task automatic check_order(input string tag, input int n, input logic [15:0] order);
    checkOutput({tag, "_count"}, acc_log.size(), n);
    for (int k = 0; k < n; k++)
      checkOutput(tag, (k < acc_log.size()) ? acc_log[k] : 99, order[4*k +: 4]);
  endtask

  task automatic pulse_reset(input logic [W-1:0] dv);
    rst = 1'b1;
    model_reset();
    #1;
    checkOutput("rst_async_valid", evt_valid, 0);
    checkOutput("rst_async_level", level, 0);
    applyStimulus(dv, 1'b0, 1'b0, 2);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    applyStimulus(4'hF, 1'b0, 1'b0, 3);
    checkOutput("rst_outputs", {level, overflow, evt_valid, evt_index, evt_level}, 0);
    rst = 1'b0;

    // Inputs held high through reset become 0->1 events with normal latency.
    applyStimulus(4'hF, 1'b0, 1'b0, 5);
    checkOutput("rst_level_edge5", level, 4'h0);
    step();
    checkOutput("rst_level_edge6", level, 4'hF);
    acc_log.delete();
    applyStimulus(4'hF, 1'b1, 1'b0, 20);
    check_order("rst_order", 4, 16'h3210);
    applyStimulus(4'h0, 1'b1, 1'b0, 20);

    applyStimulus(4'h4, 1'b0, 1'b0, 5);
    checkOutput("lat_level_edge5", level, 4'h0);
    step();
    checkOutput("lat_level_edge6", level, 4'h4);
    checkOutput("lat_valid_edge6", evt_valid, 0);
    step();
    checkOutput("lat_valid_edge7", evt_valid, 1);
    checkOutput("lat_index_edge7", evt_index, 2);
    checkOutput("lat_evtlvl_edge7", evt_level, 1);
    applyStimulus(4'h4, 1'b1, 1'b0, 1);
    checkOutput("lat_valid_after_accept", evt_valid, 0);

    acc_log.delete();
    applyStimulus(4'h6, 1'b1, 1'b0, 3);
    applyStimulus(4'h4, 1'b1, 1'b0, 12);
    checkOutput("glitch_level", level, 4'h4);
    checkOutput("glitch_events", acc_log.size(), 0);

    // Accepting channel 0 leaves ptr at 1 before the simultaneous burst.
    applyStimulus(4'h5, 1'b1, 1'b0, 10);
    acc_log.delete();
    applyStimulus(4'hE, 1'b1, 1'b0, 20);
    check_order("rr_order", 3, 16'h0031);
    acc_log.delete();
    applyStimulus(4'hB, 1'b1, 1'b0, 20);
    check_order("rr_ptr_after", 2, 16'h0002);

    // Channel 3 occupies the offer while channel 0 changes twice.
    applyStimulus(4'hA, 1'b1, 1'b0, 12);
    applyStimulus(4'h2, 1'b0, 1'b0, 0);
    wait_offer(20);
    checkOutput("ovf_hold_index", evt_index, 3);
    applyStimulus(4'h3, 1'b0, 1'b0, 10);
    applyStimulus(4'h2, 1'b0, 1'b0, 12);
    checkOutput("ovf_set", overflow, 4'h1);
    acc_log.delete();
    applyStimulus(4'h2, 1'b1, 1'b0, 2);
    checkOutput("ovf_offer_valid", evt_valid, 1);
    checkOutput("ovf_offer_index", evt_index, 0);
    checkOutput("ovf_offer_level", evt_level, 0);
    applyStimulus(4'h2, 1'b1, 1'b0, 10);
    check_order("ovf_order", 2, 16'h0003);
    checkOutput("ovf_sticky", overflow, 4'h1);
    applyStimulus(4'h2, 1'b1, 1'b1, 1);
    checkOutput("ovf_cleared", overflow, 4'h0);

    applyStimulus(4'h6, 1'b0, 1'b0, 0);
    wait_offer(20);
    pulse_reset(4'h6);
    acc_log.delete();
    applyStimulus(4'h6, 1'b1, 1'b0, 20);
    checkOutput("rstmid_level", level, 4'h6);
    check_order("rstmid_order", 2, 16'h0021);
    applyStimulus(4'h0, 1'b0, 1'b0, 0);
    wait_offer(20);
    pulse_reset(4'h0);
    acc_log.delete();
    applyStimulus(4'h0, 1'b1, 1'b0, 20);
    checkOutput("rstmid_no_reoffer", acc_log.size(), 0);
    checkOutput("rstmid_level_low", level, 4'h0);

    for (int n = 0; n < 2000; n++) begin
      int bitn;
      if ($urandom_range(0, 5) == 0) begin
        bitn = $urandom_range(0, W - 1);
        d[bitn] = ~d[bitn];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    tests_failed++;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/async_event_arbiter.md
ASYNC_EVENT_ARBITER -- requirements
Module: async_event_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of asynchronous input channels, legal range 2..32.
REQ-002 SHALL have parameter LENGTH, default 2: synchronizer stages per channel, minimum 2.
REQ-003 SHALL have parameter DEBOUNCE, default 4: consecutive cycles of stable mismatch needed to accept a level change, minimum 1.
REQ-004 SHALL have port clk  input  1  the single clock; all state is in this domain.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port d  input  WIDTH  asynchronous level inputs, unrelated to clk.
REQ-007 SHALL have port level  output  WIDTH  debounced, synchronized level per channel.
REQ-008 SHALL have port evt_valid  output  1  event offered.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts the offered event.
REQ-010 SHALL have port evt_index  output  $clog2(WIDTH)  channel of the offered event.
REQ-011 SHALL have port evt_level  output  1  new level of the offered channel.
REQ-012 SHALL have port overflow  output  WIDTH  sticky flag per channel: an event was merged before it was reported.
REQ-013 SHALL have port ovf_clear  input  1  clears all overflow bits.

Function
REQ-014 SHALL pass each d[i] through a LENGTH-stage flip-flop shift chain; the last stage is sync[i].
REQ-015 SHALL keep a per-channel debounce counter that clears whenever sync[i]==level[i] and increments whenever they differ.
REQ-016 SHALL toggle level[i] on the edge where sync[i]!=level[i] has held for DEBOUNCE consecutive cycles, and clear that counter on the same edge.
REQ-017 SHALL produce latency as follows: a d[i] step that stays stable updates level[i] LENGTH+DEBOUNCE edges after the first sampling edge.
REQ-018 SHALL set pending[i] on the same edge on which level[i] toggles.
REQ-019 SHALL set overflow[i] if level[i] toggles while pending[i] is already 1 and is not being cleared by an accept on that edge; pending stays 1.
REQ-020 SHALL make set win over clear: a toggle on the accept edge of the same channel leaves pending[i]=1 and does not set overflow[i].
REQ-021 SHALL use a two-state arbiter, IDLE and OFFER, with a round-robin pointer ptr, reset 0.
REQ-022 SHALL, in IDLE with any pending bit set, choose the first pending index at or above ptr (wrapping modulo WIDTH), register evt_index and evt_level=level[idx], and go to OFFER; evt_valid is then 1 on the next cycle.
REQ-023 SHALL, in OFFER, hold evt_valid=1 with evt_index and evt_level stable until evt_ready=1.
REQ-024 SHALL, on an edge with evt_valid and evt_ready both 1, clear pending[evt_index], set ptr to (evt_index+1) mod WIDTH, and return to IDLE; minimum gap between accepted events is one cycle.
REQ-025 SHALL offer the latest level on the next offer for a channel that toggles during OFFER; the already-offered evt_level is not altered.
REQ-026 SHALL clear all overflow bits when ovf_clear=1, except that a same-edge overflow set wins.
REQ-027 SHALL keep evt_valid at 0 in IDLE; evt_index and evt_level are don't-care when evt_valid=0.

Reset
REQ-028 SHALL, while rst=1, asynchronously force to 0: all synchronizer stages, counters, level, pending, overflow, ptr, evt_valid, evt_index and evt_level; the state becomes IDLE.
REQ-029 SHALL discard on reset any event in OFFER or pending without reporting it; after rst falls, d inputs at 1 produce 0->1 events through the normal latency.

Verification (WIDTH=4, LENGTH=2, DEBOUNCE=4)
REQ-030 SHALL check reset: with rst=1 and d=4'hF, all outputs are 0; after rst falls, level becomes 4'hF after 6 edges and events are offered for indices 0, 1, 2, 3 in order.
REQ-031 SHALL check latency: d[2] goes 0->1 and is held; level[2]=1 at edge 6, evt_valid=1 at edge 7 with evt_index=2 and evt_level=1; evt_ready=1 then gives evt_valid=0 the next cycle.
REQ-032 SHALL check the glitch filter: d[1] high for 3 cycles only produces no level change and no event.
REQ-033 SHALL check round-robin: with ptr=1 and pending={0,1,3} set together and evt_ready held 1, the accepted order is 1, 3, 0, and ptr ends at 1.
REQ-034 SHALL check overflow: with evt_ready=0, d[0] goes 0->1, then 1->0 after 10 cycles; overflow[0]=1 and the single event reports evt_level=0; ovf_clear=1 returns overflow to 0.
REQ-035 SHALL check reset mid-offer: rst pulses while evt_valid=1; evt_valid=0 immediately (asynchronously) and the event is not re-offered unless a d level persists.
